piezo_sound_sequencer: RTL
==========================

# piezo_sound_sequencer

Shared-buzzer controller for the game board. Game-event logic raises one-cycle sound requests (key click, game start, game over, game clear). The block arbitrates them by fixed priority, queues losers, and steps through a per-sound note list with note and gap timers. It drives the piezo pin with a square wave from an internal half-period divider and runs on the 1 kHz system clock (1 cycle = 1 ms).

## Interface
- GAP_CYC, 10, silent cycles after every note (1..255)
- clk  in  1  system clock, 1 kHz
- rst  in  1  reset, asynchronous, active-high
- req  in  4  one-cycle request pulses; bit 0 click, 1 start, 2 over, 3 clear; higher index = higher priority
- mute  in  1  forces piezo_out low; sequencing unaffected
- piezo_out  out  1  square wave to buzzer
- busy  out  1  high while a sound is in PLAY or GAP
- active_id  out  2  ID of sound being played (0 when idle)
- note_idx  out  2  index of current note within sound

## Operation
- Reset: state IDLE; pending=0, piezo_out=0, busy=0, active_id=0, note_idx=0; all counters 0. Applied mid-sound, the sound aborts immediately and nothing resumes.
- Note ROM entries are (div, dur). Half-period is div cycles; f = 1 kHz / (2·div).
  - ID0 click: (1,20).
  - ID1 start: (4,100),(2,100).
  - ID2 over: (2,150),(4,150),(8,300).
  - ID3 clear: (8,100),(4,100),(2,100),(1,100).
- pending[3:0]: each req bit sets its pending bit at the clock edge. A bit clears when that ID is launched. If set and clear happen on the same edge, set wins, so the sound replays later.
- Launch picks the highest set pending bit. It loads active_id, sets note_idx=0 and enters PLAY.
- States:
  - IDLE: if pending≠0, launch; else stay.
  - PLAY: dur_cnt counts 0..dur-1. At dur-1, go to GAP.
  - GAP: gap_cnt counts 0..GAP_CYC-1. At the end, if note_idx < last, increment note_idx and re-enter PLAY; else go to IDLE (active_id, note_idx → 0).
- Tone generator:
  - On entry to PLAY, half_cnt=0 and piezo_out=0.
  - In PLAY, half_cnt counts to div-1, then piezo_out toggles and half_cnt wraps to 0.
  - In IDLE and GAP, piezo_out=0 and half_cnt=0.
  - mute gates the pin output only; the internal toggle register keeps running.
- Simultaneous requests: all bits latch into pending and are served in descending ID order, one sound at a time.
- A req for the ID currently playing only sets pending. That sound replays after the current one finishes and is never restarted mid-play.

## Timing
- A req on edge k, with IDLE and nothing pending, puts busy=1, state PLAY and note_idx=0 visible after edge k+1 (1-cycle latency).
- busy high time = Σ(dur+GAP_CYC) over the sound's notes.
- First piezo_out toggle occurs div cycles after PLAY entry.
- After a sound ends, one IDLE cycle (busy=0) always precedes the next launch.
- Counters: dur_cnt 9 bits, half_cnt 4 bits, gap_cnt 8 bits. None wrap beyond their terminal count.

## Configuration
- PIEZO_PREEMPT_EN defined:
  - In PLAY or GAP, if the highest pending ID is strictly greater than active_id, that ID launches on the next edge.
  - The interrupted sound is discarded and not re-queued.
  - piezo_out restarts low at the new note.
- PIEZO_PREEMPT_EN undefined: no preemption; pending requests wait for IDLE.

## Test plan
- Reset mid-sound:
  - Start ID3, assert rst at cycle 50.
  - Outputs go 0 asynchronously.
  - After release, with no req, busy stays 0 for 100 cycles.
- Click: req=0001 at cycle 0.
  - busy=1 on cycles 1..30.
  - piezo_out toggles every cycle during cycles 1..20, then is 0 for 10 cycles.
- Clear melody: req=1000.
  - busy exactly 440 cycles.
  - Toggle periods measured 16, 8, 4, 2 cycles per full wave.
  - note_idx steps 0→3.
- Simultaneous: req=0101 on one cycle.
  - ID2 plays first (630 busy cycles), then 1 idle cycle, then ID0 (30 busy cycles).
- Preemption:
  - Scenario: ID1 playing, req=0100 at cycle 40 of note 0.
  - With PIEZO_PREEMPT_EN: active_id=2 next cycle, ID1 never resumes.
  - Without: ID1 completes (220 cycles), then ID2 plays.
- Mute and retrigger:
  - mute=1 during ID0 keeps piezo_out=0 while busy timing stays unchanged.
  - A repeat req=0001 mid-sound causes exactly one replay afterwards.

Source files
------------

// File: rtl/piezo_sound_sequencer_if.sv
// Buzzer sequencer request/status bundle: the game logic side is master,
// the sequencer is slave.
interface piezo_sound_sequencer_if;
    logic [3:0] req;
    logic       mute;
    logic       piezo_out;
    logic       busy;
    logic [1:0] active_id;
    logic [1:0] note_idx;

    modport master (output req, mute, input piezo_out, busy, active_id, note_idx);
    modport slave  (input req, mute, output piezo_out, busy, active_id, note_idx);
endinterface

// File: rtl/piezo_sound_sequencer.sv
// Shared-buzzer sequencer: fixed-priority request queue, per-sound note ROM,
// note/gap timers and half-period tone divider. Optional PIEZO_PREEMPT_EN.
module piezo_sound_sequencer #(
    parameter int GAP_CYC = 10
) (
    input logic                   clk,
    input logic                   rst,
    piezo_sound_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2} state_t;
    typedef struct packed {
        logic [3:0] div;
        logic [8:0] dur;
    } note_t;

    state_t     state, state_nxt;
    logic [3:0] pending, pend_clr;
    logic [1:0] active_id, note_idx, top_id;
    logic [8:0] dur_cnt;
    logic [7:0] gap_cnt;
    logic [3:0] half_cnt;
    logic       tone;
    note_t      cur;
    logic       launch, preempt, dur_end, gap_end, next_note, note_start, keep_play;

    function automatic note_t note_rom(input logic [3:0] sel);
        case (sel)
            4'h0:    note_rom = '{div: 4'd1, dur: 9'd20};
            4'h4:    note_rom = '{div: 4'd4, dur: 9'd100};
            4'h5:    note_rom = '{div: 4'd2, dur: 9'd100};
            4'h8:    note_rom = '{div: 4'd2, dur: 9'd150};
            4'h9:    note_rom = '{div: 4'd4, dur: 9'd150};
            4'hA:    note_rom = '{div: 4'd8, dur: 9'd300};
            4'hC:    note_rom = '{div: 4'd8, dur: 9'd100};
            4'hD:    note_rom = '{div: 4'd4, dur: 9'd100};
            4'hE:    note_rom = '{div: 4'd2, dur: 9'd100};
            4'hF:    note_rom = '{div: 4'd1, dur: 9'd100};
            default: note_rom = '{div: 4'd1, dur: 9'd1};
        endcase
    endfunction

    always_comb begin
        top_id = 2'd0;
        for (int i = 0; i < 4; i++)
            if (pending[i]) top_id = 2'(i);
    end

    assign cur       = note_rom({active_id, note_idx});
    assign dur_end   = (state == PLAY) && (dur_cnt == cur.dur - 9'd1);
    assign gap_end   = (state == GAP) && (gap_cnt == 8'(GAP_CYC - 1));
    // Sound ID doubles as its last note index (ID n has n+1 notes).
    assign next_note = gap_end && (note_idx < active_id);

`ifdef PIEZO_PREEMPT_EN
    assign preempt = (state != IDLE) && (|pending) && (top_id > active_id);
`else
    assign preempt = 1'b0;
`endif

    assign launch     = ((state == IDLE) && (|pending)) || preempt;
    assign note_start = launch || next_note;
    assign keep_play  = (state == PLAY) && (state_nxt == PLAY) && !note_start;
    assign pend_clr   = launch ? (4'b0001 << top_id) : 4'b0000;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nxt;

    always_comb begin
        state_nxt = state;
        if (launch) state_nxt = PLAY;
        else case (state)
            PLAY:    if (dur_end) state_nxt = GAP;
            GAP:     if (gap_end) state_nxt = next_note ? PLAY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state != IDLE);
        bus.piezo_out = tone & ~bus.mute;
        bus.active_id = active_id;
        bus.note_idx  = note_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= '0;
            active_id <= '0;
            note_idx  <= '0;
            dur_cnt   <= '0;
            gap_cnt   <= '0;
            half_cnt  <= '0;
            tone      <= 1'b0;
        end else begin
            // New requests OR in after the launch clear, so a same-edge retrigger survives.
            pending <= (pending & ~pend_clr) | bus.req;

            if (launch) begin
                active_id <= top_id;
                note_idx  <= 2'd0;
            end else if (next_note) begin
                note_idx  <= note_idx + 2'd1;
            end else if (gap_end) begin
                active_id <= 2'd0;
                note_idx  <= 2'd0;
            end

            dur_cnt <= keep_play ? dur_cnt + 9'd1 : 9'd0;
            gap_cnt <= ((state == GAP) && (state_nxt == GAP)) ? gap_cnt + 8'd1 : 8'd0;

            if (keep_play) begin
                if (half_cnt == cur.div - 4'd1) begin
                    half_cnt <= 4'd0;
                    tone     <= ~tone;
                end else begin
                    half_cnt <= half_cnt + 4'd1;
                end
            end else begin
                half_cnt <= 4'd0;
                tone     <= 1'b0;
            end
        end
    end
endmodule
